// File: rtl/serial_adder_if.sv
// Handshake/result bundle for serial_adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );
  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus carry flop, LSB first, WIDTH cycles per add.
// SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serial_adder_if.slave io_bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr, r_sum;
  logic [WIDTH-1:0] w_sum_sr_next;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry, r_c_out;
  logic             w_accept, w_last, w_s, w_carry_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  // A start is only honoured outside SHIFT; DONE accepts it for back-to-back adds.
  assign w_accept      = io_bus.start && (r_state != StShift);
  assign w_last        = (r_cnt == CntW'(WIDTH - 1));
  assign w_s           = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_carry_next  = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
  assign w_sum_sr_next = (r_sum_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = io_bus.start ? StShift : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sum    <= '0;
      r_c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_sr   <= io_bus.a;
        r_b_sr   <= io_bus.b;
        r_carry  <= io_bus.c_in;
        r_sum_sr <= '0;
        r_cnt    <= '0;
      end else if (r_state == StShift) begin
        r_a_sr   <= r_a_sr >> 1;
        r_b_sr   <= r_b_sr >> 1;
        r_carry  <= w_carry_next;
        r_sum_sr <= w_sum_sr_next;
        r_cnt    <= r_cnt + CntW'(1);
        if (w_last) begin
          r_sum   <= w_sum_sr_next;
          r_c_out <= w_carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last step r_carry holds the carry into the MSB.
          r_ovf   <= r_carry ^ w_carry_next;
`endif
        end
      end
    end
  end

  assign io_bus.busy  = (r_state == StShift);
  assign io_bus.done  = (r_state == StDone);
  assign io_bus.sum   = r_sum;
  assign io_bus.c_out = r_c_out;
`ifdef SERIAL_ADDER_OVF_EN
  assign io_bus.ovf   = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8 and WIDTH=1) with a result scoreboard.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_rst(rst), .io_bus(if8));
  serial_adder #(.WIDTH(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .io_bus(if1));

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_res;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf_q[$];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start on the WIDTH=8 DUT; returns just after the accepting edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit push);
    logic [8:0] e;
    e = 9'(a) + 9'(b) + 9'(cin);
    if (push) begin
      exp_q.push_back(e);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q.push_back((a[7] == b[7]) && (e[7] != a[7]));
`endif
    end
    if8.start = 1'b1;
    if8.a     = a;
    if8.b     = b;
    if8.c_in  = cin;
    tick();
    if8.start = 1'b0;
    chk("busy_after_accept", 32'(if8.busy), 32'd1);
  endtask

  task automatic wait8(input string tag, input int lat);
    int         n;
    logic [8:0] e;
    n = 0;
    while (!if8.done && n < 20) begin
      chk("busy_during_shift", 32'(if8.busy), 32'd1);
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_low"}, 32'(if8.busy), 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
    chk({tag, "_result"}, 32'({if8.c_out, if8.sum}), 32'(e));
    last_res = e;
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(if8.ovf), 32'((ovf_q.size() > 0) ? ovf_q.pop_front() : 1'bx));
`endif
  endtask

  task automatic no_done8(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (if8.done) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0] v;
    logic [8:0] e;
    int         n;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.c_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_result", 32'({if8.c_out, if8.sum}), 32'd0);
    chk("rst_w1_result", 32'({if1.c_out, if1.sum, if1.busy, if1.done}), 32'd0);

    go8(8'h00, 8'h00, 1'b0, 1'b1);
    wait8("zero", 8);

    go8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait8("ff_plus_1", 8);
    // Issue from the DONE cycle: must be accepted on the very next edge.
    go8(8'hA5, 8'h5A, 1'b1, 1'b1);
    chk("b2b_done_cleared", 32'(if8.done), 32'd0);
    wait8("a5_5a_c1", 8);

`ifdef SERIAL_ADDER_OVF_EN
    go8(8'h7F, 8'h01, 1'b0, 1'b1);
    wait8("ovf_pos", 8);
    go8(8'h80, 8'h80, 1'b0, 1'b1);
    wait8("ovf_neg", 8);
    go8(8'h10, 8'h20, 1'b0, 1'b1);
    wait8("ovf_none", 8);
`endif

    // Second start while busy must be ignored; previous result held meanwhile.
    go8(8'h0F, 8'h01, 1'b0, 1'b1);
    chk("hold_during_shift", 32'({if8.c_out, if8.sum}), 32'(last_res));
    tick();
    tick();
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.c_in = 1'b1;
    tick();
    if8.start = 1'b0;
    wait8("ignore_start", 5);
    no_done8("single_done_pulse", 10);
    chk("hold_in_idle", 32'({if8.c_out, if8.sum}), 32'h010);

    // Reset in the 4th SHIFT cycle abandons the add.
    go8(8'h55, 8'h55, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(if8.busy), 32'd0);
    chk("abort_done", 32'(if8.done), 32'd0);
    chk("abort_result", 32'({if8.c_out, if8.sum}), 32'd0);
    no_done8("abort_no_done", 12);
    go8(8'h03, 8'h04, 1'b0, 1'b1);
    wait8("after_abort", 8);

    // rst and start together: rst wins.
    tick();
    rst = 1'b1;
    if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h22;
    tick();
    rst = 1'b0;
    if8.start = 1'b0;
    chk("rst_beats_start_busy", 32'(if8.busy), 32'd0);
    no_done8("rst_beats_start_done", 10);

    // WIDTH=1 truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp_q.push_back(9'(v[2]) + 9'(v[1]) + 9'(v[0]));
      if1.start = 1'b1; if1.a = v[2]; if1.b = v[1]; if1.c_in = v[0];
      tick();
      if1.start = 1'b0;
      n = 0;
      while (!if1.done && n < 10) begin
        tick();
        n++;
      end
      chk("w1_latency", 32'(n), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
      chk("w1_result", 32'({if1.c_out, if1.sum}), 32'(e));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder and the sequential successor to the lab full-adder cell.
- Latches two WIDTH-bit operands and a carry-in on a start pulse.
- Adds one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop.
- Presents the registered sum and carry-out with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/sum width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- c_in  input  1  carry-in; captured on accepted start
- busy  output  1  high while a bit-serial add is in progress
- done  output  1  one-cycle pulse: sum/c_out just updated
- sum  output  WIDTH  registered result
- c_out  output  1  registered carry-out

Behaviour:
- Reset and clocking: one clock, clk; rst is synchronous and active-high. While rst is sampled high at a clk edge, every output and all state go to 0: busy=0, done=0, sum=0, c_out=0, FSM=IDLE, counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → capture a, b into internal shift registers; carry flop←c_in; bit counter←0; sum shift register←0.
  - Next state SHIFT; busy=1 from the next cycle.
- SHIFT, each cycle:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry ← majority(a_sr[0], b_sr[0], carry).
  - s shifts into the MSB of the sum shift register; a_sr and b_sr shift right; counter increments.
  - When counter==WIDTH-1 (the last bit is being processed), next state DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - Output regs sum←sum shift register; c_out←carry. These are loaded on the SHIFT→DONE edge, so they are valid in the same cycle done is high.
  - start=1 here → accepted exactly as in IDLE and next state SHIFT; else next state IDLE.
- Latency: start accepted at edge T → busy high over edges T+1..T+WIDTH → done high for the cycle after edge T+WIDTH. Exactly WIDTH SHIFT cycles per add. Back-to-back throughput is one result per WIDTH+1 cycles.
- Output stability:
  - sum/c_out change only on SHIFT→DONE and on reset.
  - They hold their last result through IDLE and through a subsequent add until its own DONE.
- Boundary conditions:
  - start while busy (SHIFT): ignored; no capture, no queuing; a/b/c_in changes during SHIFT have no effect.
  - WIDTH=1: a single SHIFT cycle; behaves as the full adder, registered.
  - Carry out of the MSB goes only to c_out; no wrap into bit 0.
  - rst asserted mid-SHIFT: operation abandoned; the next cycle has all outputs 0, IDLE, and no done pulse for the aborted add.
  - rst and start high in the same cycle: rst wins; start is not captured.
- Arithmetic: {c_out,sum} == a + b + c_in, unsigned, WIDTH+1 bits.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0), loaded alongside sum on SHIFT→DONE.
  - ovf = two's-complement signed overflow = carry into MSB XOR carry out of MSB. This requires a flop holding the MSB-stage carry-in.
  - Held like sum.
- Undefined: no ovf port, no extra flop; behaviour otherwise identical.

Test Plan:
- WIDTH=8: rst 2 cycles, then a=0x00, b=0x00, c_in=0, start 1 cycle → busy for 8 cycles, done pulse 9 cycles after start edge, sum=0x00, c_out=0.
- WIDTH=8: a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1; then a=0xA5, b=0x5A, c_in=1 issued in the DONE cycle → accepted immediately; sum=0x00, c_out=1 after 8 more SHIFT cycles.
- WIDTH=8 with SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, c_in=0 → sum=0x80, c_out=0, ovf=1; then a=0x80, b=0x80 → sum=0x00, c_out=1, ovf=1; then 0x10+0x20 → 0x30, ovf=0.
- Start a=0x0F, b=0x01; pulse start again with a=0xFF, b=0xFF 3 cycles later → second start ignored; result sum=0x10, c_out=0; exactly one done pulse.
- Start a=0x55, b=0x55; assert rst at the 4th SHIFT cycle → next cycle busy=0, done=0, sum=0x00, c_out=0; no done pulse follows; a fresh add 0x03+0x04 → 0x07.
- WIDTH=1: all 8 {a,b,c_in} combinations in the truth-table order 000..111 → {c_out,sum} = 00,01,01,10,01,10,10,11, each with done 2 cycles after start.
